alu_seq_ctrl: RTL and testbench

Execution sequencer for the accumulator processor's n-bit ALU (external `alu_nbit` instance). It accepts one opcode/operand per valid/ready handshake and drives the ALU control, data and carry-in lines. It owns the accumulator and the C/V/Z flag registers. MUL runs as an N-cycle shift-add loop that reuses the ALU adder.

---
 rtl/alu_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Execution sequencer for the accumulator processor: drives an external n-bit ALU,
// owns the accumulator and C/V/Z flags, and runs MUL as an N-step shift-add loop.
module alu_seq_ctrl #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         op_valid,
   output logic         op_ready,
   input  logic [3:0]   opcode,
   input  logic [N-1:0] operand,
   output logic [N-1:0] alu_in0,
   output logic [N-1:0] alu_in1,
   output logic         alu_cin,
   output logic [2:0]   alu_ctrl,
   input  logic [N-1:0] alu_out,
   input  logic         alu_cout,
   input  logic         alu_v,
   output logic [N-1:0] acc,
   output logic         flag_c,
   output logic         flag_v,
   output logic         flag_z,
   output logic         done,
   output logic         err
);

   localparam int CW = $clog2(N + 1);

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LDA  = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_ADC  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_AND  = 4'd6;
   localparam logic [3:0] OP_ANDN = 4'd7;
   localparam logic [3:0] OP_NOT  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;
   localparam logic [3:0] OP_CLF  = 4'd10;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_OR   = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b100;
   localparam logic [2:0] ALU_ANDN = 3'b101;
   localparam logic [2:0] ALU_NOT  = 3'b110;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EXEC     = 2'd1,
      MUL_STEP = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic           accept;
   logic [3:0]     op_q;
   logic [N-1:0]   opnd_q;
   logic [N-1:0]   mul_m;
   logic [N-1:0]   mul_q;
   logic [N-1:0]   mul_p;
   logic [N-1:0]   mul_p_nxt;
   logic [CW-1:0]  mul_cnt;
   logic           mul_last;

   function automatic logic is_zero(input logic [N-1:0] x);
      return (x == '0);
   endfunction

   assign accept    = op_valid && op_ready;
   assign mul_p_nxt = mul_q[0] ? alu_out : mul_p;
   assign mul_last  = (mul_cnt == CW'(1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; DONE accepts like IDLE so back-to-back ops take two cycles each
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (accept) begin
               state_nxt = (opcode == OP_MUL) ? MUL_STEP : EXEC;
            end else begin
               state_nxt = IDLE;
            end
         end
         EXEC:     state_nxt = DONE;
         MUL_STEP: state_nxt = mul_last ? DONE : MUL_STEP;
         default:  state_nxt = IDLE;
      endcase
   end

   // Output logic: handshake and ALU drive
   always_comb begin
      op_ready = (state == IDLE) || (state == DONE);
      alu_ctrl = ALU_ADD;
      alu_in0  = '0;
      alu_in1  = '0;
      alu_cin  = 1'b0;
      case (state)
         EXEC: begin
            alu_in0 = acc;
            alu_in1 = opnd_q;
            case (op_q)
               OP_ADC:  alu_cin = flag_c;
               OP_SUB: begin
                  alu_ctrl = ALU_SUB;
                  alu_cin  = 1'b1;
               end
               OP_OR:   alu_ctrl = ALU_OR;
               OP_AND:  alu_ctrl = ALU_AND;
               OP_ANDN: alu_ctrl = ALU_ANDN;
               OP_NOT:  alu_ctrl = ALU_NOT;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         MUL_STEP: begin
            alu_in0 = mul_p;
            alu_in1 = mul_m;
         end
         default: ;
      endcase
   end

   // Captured opcode/operand only matter while the op executes
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q   <= opcode;
         opnd_q <= operand;
      end
   end

   // Accumulator, flags, multiplier registers and completion pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         flag_c  <= 1'b0;
         flag_v  <= 1'b0;
         flag_z  <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         mul_m   <= '0;
         mul_q   <= '0;
         mul_p   <= '0;
         mul_cnt <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (accept && (opcode == OP_MUL)) begin
            mul_m   <= acc;
            mul_q   <= operand;
            mul_p   <= '0;
            mul_cnt <= CW'(N);
         end
         case (state)
            EXEC: begin
               done <= 1'b1;
               case (op_q)
                  OP_NOP: ;
                  OP_LDA: begin
                     acc    <= opnd_q;
                     flag_z <= is_zero(opnd_q);
                  end
                  OP_ADD, OP_ADC, OP_SUB: begin
                     acc    <= alu_out;
                     flag_c <= alu_cout;
                     flag_v <= alu_v;
                     flag_z <= is_zero(alu_out);
                  end
                  OP_OR, OP_AND, OP_ANDN, OP_NOT: begin
                     acc    <= alu_out;
                     flag_z <= is_zero(alu_out);
                  end
                  OP_CLF: begin
                     flag_c <= 1'b0;
                     flag_v <= 1'b0;
                     flag_z <= 1'b0;
                  end
                  default: err <= 1'b1;
               endcase
            end
            MUL_STEP: begin
               mul_p   <= mul_p_nxt;
               mul_m   <= mul_m << 1;
               mul_q   <= mul_q >> 1;
               mul_cnt <= mul_cnt - CW'(1);
               if (mul_last) begin
                  acc    <= mul_p_nxt;
                  flag_z <= is_zero(mul_p_nxt);
                  flag_c <= 1'b0;
                  flag_v <= 1'b0;
                  done   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ALU, op-level reference model, directed
// test-plan sequences with literal expectations, then randomized traffic.
module tb_alu_seq_ctrl;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         op_valid = 1'b0;
   logic         op_ready;
   logic [3:0]   opcode = 4'd0;
   logic [N-1:0] operand = '0;
   logic [N-1:0] alu_in0, alu_in1, alu_out;
   logic         alu_cin, alu_cout, alu_v;
   logic [2:0]   alu_ctrl;
   logic [N-1:0] acc;
   logic         flag_c, flag_v, flag_z, done, err;

   int total = 0;
   int bad = 0;

   alu_seq_ctrl #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
      .opcode(opcode), .operand(operand), .alu_in0(alu_in0), .alu_in1(alu_in1),
      .alu_cin(alu_cin), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_cout(alu_cout),
      .alu_v(alu_v), .acc(acc), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // External ALU stand-in
   logic [N:0] alu_sum;
   always_comb begin
      alu_sum  = '0;
      alu_out  = '0;
      alu_cout = 1'b0;
      alu_v    = 1'b0;
      case (alu_ctrl)
         3'b000: begin
            alu_sum  = {1'b0, alu_in0} + {1'b0, alu_in1} + {{N{1'b0}}, alu_cin};
            alu_out  = alu_sum[N-1:0];
            alu_cout = alu_sum[N];
            alu_v    = (alu_in0[N-1] == alu_in1[N-1]) && (alu_out[N-1] != alu_in0[N-1]);
         end
         3'b001: begin
            alu_sum  = {1'b0, alu_in0} + {1'b0, ~alu_in1} + {{N{1'b0}}, alu_cin};
            alu_out  = alu_sum[N-1:0];
            alu_cout = alu_sum[N];
            alu_v    = (alu_in0[N-1] != alu_in1[N-1]) && (alu_out[N-1] != alu_in0[N-1]);
         end
         3'b010: alu_out = alu_in0 | alu_in1;
         3'b100: alu_out = alu_in0 & alu_in1;
         3'b101: alu_out = alu_in0 & ~alu_in1;
         3'b110: alu_out = ~alu_in0;
         default: ;
      endcase
   end

   // Reference model: committed state plus a pending result released after a latency
   int m_acc, m_c, m_v, m_z, m_done, m_err;
   int p_acc, p_c, p_v, p_z, p_err;
   int busy;

   function automatic int sx(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int a, b, cin, s, sv, r, c, v, z, e;
      bit take;
      if (!rst_n) begin
         m_acc <= 0; m_c <= 0; m_v <= 0; m_z <= 0; m_done <= 0; m_err <= 0;
         busy <= 0;
      end else begin
         take = op_valid && (busy == 0);
         m_done <= 0;
         m_err  <= 0;
         if (busy == 1) begin
            m_acc <= p_acc; m_c <= p_c; m_v <= p_v; m_z <= p_z;
            m_done <= 1; m_err <= p_err;
            busy <= 0;
         end else if (busy > 1) begin
            busy <= busy - 1;
         end
         if (take) begin
            a = m_acc; b = int'(operand);
            r = m_acc; c = m_c; v = m_v; z = m_z; e = 0;
            case (int'(opcode))
               0: ;
               1: begin r = b; z = (r == 0); end
               2, 3: begin
                  cin = (opcode == 4'd3) ? m_c : 0;
                  s = a + b + cin; r = s % 256; c = (s > 255);
                  sv = sx(a) + sx(b) + cin; v = (sv > 127 || sv < -128);
                  z = (r == 0);
               end
               4: begin
                  r = (a - b + 256) % 256; c = (a >= b);
                  sv = sx(a) - sx(b); v = (sv > 127 || sv < -128);
                  z = (r == 0);
               end
               5: begin r = a | b; z = (r == 0); end
               6: begin r = a & b; z = (r == 0); end
               7: begin r = a & (255 - b); z = (r == 0); end
               8: begin r = 255 - a; z = (r == 0); end
               9: begin r = (a * b) % 256; c = 0; v = 0; z = (r == 0); end
               10: begin c = 0; v = 0; z = 0; end
               default: e = 1;
            endcase
            p_acc <= r; p_c <= c; p_v <= v; p_z <= z; p_err <= e;
            busy <= (opcode == 4'd9) ? N : 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle compare against the model
   always @(negedge clk) begin
      chk("op_ready", int'(op_ready), int'(busy == 0));
      chk("done", int'(done), m_done);
      chk("err", int'(err), m_err);
      chk("acc", int'(acc), m_acc);
      chk("flag_c", int'(flag_c), m_c);
      chk("flag_v", int'(flag_v), m_v);
      chk("flag_z", int'(flag_z), m_z);
      if (busy == 0) begin
         chk("idle_drive", int'({alu_ctrl, alu_cin, alu_in0, alu_in1}), 0);
      end
   end

   task automatic wait_ready();
      int i;
      for (i = 0; i < 50 && !op_ready; i++) begin
         @(negedge clk); #1;
      end
      chk("ready_timeout", int'(op_ready), 1);
   endtask

   task automatic wait_done(output int lat);
      int got;
      got = 0;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         lat++;
         if (done) begin
            got = 1;
            break;
         end
      end
      chk("done_timeout", got, 1);
   endtask

   task automatic send(input int op, input int d, output int lat);
      @(negedge clk); #1;
      op_valid = 1'b1;
      opcode   = 4'(op);
      operand  = N'(d);
      wait_ready();
      @(posedge clk); #1;
      op_valid = 1'b0;
      wait_done(lat);
   endtask

   initial begin
      int lat, got;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // 1: signed overflow on ADD
      send(1, 8'h7F, lat);
      chk("t1_lda_lat", lat, 2);
      send(2, 8'h01, lat);
      chk("t1_lat", lat, 2);
      chk("t1_acc", int'(acc), 8'h80);
      chk("t1_cvz", int'({flag_c, flag_v, flag_z}), 3'b010);

      // 2: carry out then ADC
      send(1, 8'hFF, lat);
      send(2, 8'h01, lat);
      chk("t2_acc", int'(acc), 8'h00);
      chk("t2_cvz", int'({flag_c, flag_v, flag_z}), 3'b101);
      send(3, 8'h00, lat);
      chk("t2_adc_acc", int'(acc), 8'h01);
      chk("t2_adc_cvz", int'({flag_c, flag_v, flag_z}), 3'b000);

      // 3: SUB borrow convention, ANDN holds C
      send(1, 8'h05, lat);
      send(4, 8'h05, lat);
      chk("t3_sub0_acc", int'(acc), 8'h00);
      chk("t3_sub0_cz", int'({flag_c, flag_z}), 2'b11);
      send(4, 8'h01, lat);
      chk("t3_sub1_acc", int'(acc), 8'hFF);
      chk("t3_sub1_cz", int'({flag_c, flag_z}), 2'b00);
      send(1, 8'hF0, lat);
      send(7, 8'h30, lat);
      chk("t3_andn_acc", int'(acc), 8'hC0);
      chk("t3_andn_c", int'(flag_c), 0);

      // 4: MUL latency and wrap
      send(1, 8'h0C, lat);
      send(9, 8'h0B, lat);
      chk("t4_mul_lat", lat, N + 1);
      chk("t4_mul_acc", int'(acc), 8'h84);
      send(1, 8'h10, lat);
      send(9, 8'h10, lat);
      chk("t4_wrap_acc", int'(acc), 8'h00);
      chk("t4_wrap_cvz", int'({flag_c, flag_v, flag_z}), 3'b001);

      // 5: held op_valid during MUL, then illegal opcode
      send(1, 8'h03, lat);
      @(negedge clk); #1;
      op_valid = 1'b1; opcode = 4'd9; operand = 8'h05;
      wait_ready();
      @(posedge clk); #1;
      opcode = 4'd2; operand = 8'h01;
      wait_done(lat);
      chk("t5_mul_acc", int'(acc), 8'h0F);
      @(posedge clk); #1;
      op_valid = 1'b0;
      wait_done(lat);
      chk("t5_add_acc", int'(acc), 8'h10);
      send(15, 8'hAA, lat);
      chk("t5_err", int'({done, err}), 2'b11);
      chk("t5_err_acc", int'(acc), 8'h10);

      // 6: asynchronous reset mid-MUL
      send(1, 8'h07, lat);
      @(negedge clk); #1;
      op_valid = 1'b1; opcode = 4'd9; operand = 8'h09;
      wait_ready();
      @(posedge clk); #1;
      op_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_rst_ready", int'(op_ready), 1);
      chk("t6_rst_acc", int'(acc), 0);
      chk("t6_rst_flags", int'({flag_c, flag_v, flag_z, done, err}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      got = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk); #1;
         if (done) got = 1;
      end
      chk("t6_no_done", got, 0);

      // Randomized traffic, including op_valid while busy
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk); #1;
         op_valid = ($urandom_range(0, 9) < 6);
         opcode   = ($urandom_range(0, 4) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
         operand  = N'($urandom);
      end
      op_valid = 1'b0;
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
